// File: rtl/wb_sequencer.sv
// Writeback sequencer: accepts a writeback request, waits for the source's data dependency
// (bounded by an 8-bit counter), then drives one registered write cycle into the register bank.
module wb_sequencer (
    input  logic       clk,
    input  logic       reset,
    input  logic       wb_req,
    input  logic [3:0] wb_src,
    input  logic [4:0] wb_rd,
    input  logic       hilo_ready,
    input  logic       mem_ready,
    output logic [3:0] MENtoReg,
    output logic       RegWrite,
    output logic [4:0] reg_dest,
    output logic       wb_ack,
    output logic       busy,
    output logic       err,
    output logic       timeout
);

    localparam int unsigned SRC_W = 4;
    localparam int unsigned RD_W  = 5;
    localparam int unsigned CNT_W = 8;

    localparam logic [SRC_W-1:0] SRC_MAX  = SRC_W'(8);
    localparam logic [SRC_W-1:0] SEL_IDLE = 4'b0101;
    localparam logic [SRC_W-1:0] SEL_TMO  = 4'b1000;
    localparam logic [CNT_W-1:0] CNT_MAX  = CNT_W'(255);

    typedef enum logic [2:0] {
        IDLE  = 3'd0,
        WAIT  = 3'd1,
        WRITE = 3'd2,
        TMO   = 3'd3,
        BAD   = 3'd4
    } state_t;

    state_t           state_q, state_d;
    logic [SRC_W-1:0] src_q, src_d;
    logic [RD_W-1:0]  rd_q, rd_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;

    logic [SRC_W-1:0] sel_d;
    logic             we_d;
    logic [RD_W-1:0]  dest_d;
    logic             ack_d;
    logic             busy_d;
    logic             err_d;
    logic             tmo_d;

    // Dependency check: HI/LO codes need hilo_ready, the load/store code needs mem_ready.
    function automatic logic dep_ok(input logic [SRC_W-1:0] src,
                                    input logic hilo, input logic mem);
        logic ok;
        case (src)
            SRC_W'(0), SRC_W'(1): ok = hilo;
            SRC_W'(3):            ok = mem;
            default:              ok = 1'b1;
        endcase
        return ok;
    endfunction

    // Next state, capture registers and next-cycle output values.
    always_comb begin
        state_d = state_q;
        src_d   = src_q;
        rd_d    = rd_q;
        cnt_d   = cnt_q;

        case (state_q)
            IDLE: begin
                if (wb_req) begin
                    src_d = wb_src;
                    rd_d  = wb_rd;
                    cnt_d = '0;
                    if (wb_src > SRC_MAX) begin
                        state_d = BAD;
                    end else if (!dep_ok(wb_src, hilo_ready, mem_ready)) begin
                        state_d = WAIT;
                    end else begin
                        state_d = WRITE;
                    end
                end
            end
            WAIT: begin
                // Ready on the final count still wins over the timeout.
                if (dep_ok(src_q, hilo_ready, mem_ready)) begin
                    state_d = WRITE;
                end else if (cnt_q == CNT_MAX) begin
                    state_d = TMO;
                end else begin
                    cnt_d = cnt_q + CNT_W'(1);
                end
            end
            WRITE, TMO, BAD: state_d = IDLE;
            default:         state_d = IDLE;
        endcase

        sel_d  = SEL_IDLE;
        we_d   = 1'b0;
        dest_d = '0;
        ack_d  = 1'b0;
        err_d  = 1'b0;
        tmo_d  = 1'b0;
        busy_d = (state_d != IDLE);

        // Outputs are registered, so they are decoded from the state being entered.
        case (state_d)
            WRITE: begin
                sel_d  = src_d;
                dest_d = rd_d;
                we_d   = (rd_d != '0);
                ack_d  = 1'b1;
            end
            TMO: begin
                sel_d  = SEL_TMO;
                dest_d = rd_d;
                we_d   = (rd_d != '0);
                ack_d  = 1'b1;
                tmo_d  = 1'b1;
            end
            BAD: begin
                err_d = 1'b1;
                ack_d = 1'b1;
            end
            default: ;
        endcase
    end

    // State, capture and output registers.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q  <= IDLE;
            src_q    <= '0;
            rd_q     <= '0;
            cnt_q    <= '0;
            MENtoReg <= SEL_IDLE;
            RegWrite <= 1'b0;
            reg_dest <= '0;
            wb_ack   <= 1'b0;
            busy     <= 1'b0;
            err      <= 1'b0;
            timeout  <= 1'b0;
        end else begin
            state_q  <= state_d;
            src_q    <= src_d;
            rd_q     <= rd_d;
            cnt_q    <= cnt_d;
            MENtoReg <= sel_d;
            RegWrite <= we_d;
            reg_dest <= dest_d;
            wb_ack   <= ack_d;
            busy     <= busy_d;
            err      <= err_d;
            timeout  <= tmo_d;
        end
    end

endmodule

// File: tb/tb_wb_sequencer.sv
// Directed bench for wb_sequencer: all outputs compared as one packed vector per cycle.
module tb_wb_sequencer;

    logic       clk;
    logic       reset;
    logic       wb_req;
    logic [3:0] wb_src;
    logic [4:0] wb_rd;
    logic       hilo_ready;
    logic       mem_ready;
    logic [3:0] MENtoReg;
    logic       RegWrite;
    logic [4:0] reg_dest;
    logic       wb_ack;
    logic       busy;
    logic       err;
    logic       timeout;

    int n_total = 0;
    int n_bad   = 0;

    // {MENtoReg, RegWrite, reg_dest, wb_ack, busy, err, timeout}
    logic [13:0] obs;
    assign obs = {MENtoReg, RegWrite, reg_dest, wb_ack, busy, err, timeout};

    localparam logic [13:0] IDLE_V = 14'b0101_0_00000_0000;
    localparam logic [13:0] WAIT_V = 14'b0101_0_00000_0100;

    wb_sequencer dut (
        .clk        (clk),
        .reset      (reset),
        .wb_req     (wb_req),
        .wb_src     (wb_src),
        .wb_rd      (wb_rd),
        .hilo_ready (hilo_ready),
        .mem_ready  (mem_ready),
        .MENtoReg   (MENtoReg),
        .RegWrite   (RegWrite),
        .reg_dest   (reg_dest),
        .wb_ack     (wb_ack),
        .busy       (busy),
        .err        (err),
        .timeout    (timeout)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    function automatic logic [13:0] pk(input logic [3:0] sel, input logic we,
                                       input logic [4:0] dest, input logic ack,
                                       input logic bsy, input logic er, input logic tmo);
        return {sel, we, dest, ack, bsy, er, tmo};
    endfunction

    task automatic check(input string tag, input logic [13:0] got, input logic [13:0] exp);
        n_total++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    initial begin
        reset      = 1'b1;
        wb_req     = 1'b0;
        wb_src     = 4'd0;
        wb_rd      = 5'd0;
        hilo_ready = 1'b0;
        mem_ready  = 1'b0;
        #2 reset = 1'b0;
        #2 check("reset_async", obs, IDLE_V);
        tick();
        tick();
        check("reset_hold", obs, IDLE_V);

        // First request on the first edge after release, no-dependency code 5
        reset  = 1'b1;
        wb_req = 1'b1; wb_src = 4'd5; wb_rd = 5'd9;
        tick();
        check("src5_write", obs, pk(4'd5, 1'b1, 5'd9, 1'b1, 1'b1, 1'b0, 1'b0));
        wb_req = 1'b0;
        tick();
        check("src5_idle", obs, IDLE_V);

        // HI/LO dependency released after 10 wait cycles
        wb_req = 1'b1; wb_src = 4'd0; wb_rd = 5'd4; hilo_ready = 1'b0;
        tick();
        wb_req = 1'b0;
        check("src0_wait", obs, WAIT_V);
        for (int i = 0; i < 9; i++) begin
            tick();
            check("src0_wait_hold", obs, WAIT_V);
        end
        hilo_ready = 1'b1;
        tick();
        check("src0_write", obs, pk(4'd0, 1'b1, 5'd4, 1'b1, 1'b1, 1'b0, 1'b0));
        hilo_ready = 1'b0;
        tick();
        check("src0_idle", obs, IDLE_V);

        // Memory dependency never arrives: 256 wait cycles then TMO
        wb_req = 1'b1; wb_src = 4'd3; wb_rd = 5'd7; mem_ready = 1'b0;
        tick();
        wb_req = 1'b0;
        check("tmo_wait_first", obs, WAIT_V);
        for (int i = 0; i < 255; i++) tick();
        check("tmo_wait_last", obs, WAIT_V);
        tick();
        check("tmo_pulse", obs, pk(4'd8, 1'b1, 5'd7, 1'b1, 1'b1, 1'b0, 1'b1));
        tick();
        check("tmo_idle", obs, IDLE_V);

        // Invalid code, then a write to r0
        wb_req = 1'b1; wb_src = 4'd12; wb_rd = 5'd3;
        tick();
        wb_req = 1'b0;
        check("bad_code", obs, pk(4'd5, 1'b0, 5'd0, 1'b1, 1'b1, 1'b1, 1'b0));
        tick();
        check("bad_idle", obs, IDLE_V);
        wb_req = 1'b1; wb_src = 4'd2; wb_rd = 5'd0;
        tick();
        wb_req = 1'b0;
        check("rd0_write", obs, pk(4'd2, 1'b0, 5'd0, 1'b1, 1'b1, 1'b0, 1'b0));
        tick();
        check("rd0_idle", obs, IDLE_V);

        // Reset during WAIT discards the transaction
        wb_req = 1'b1; wb_src = 4'd1; wb_rd = 5'd5; hilo_ready = 1'b0;
        tick();
        wb_req = 1'b0;
        check("rst_wait", obs, WAIT_V);
        tick();
        tick();
        #2 reset = 1'b0;
        #1 check("rst_in_wait", obs, IDLE_V);
        #1 reset = 1'b1;
        hilo_ready = 1'b1;
        for (int i = 0; i < 3; i++) begin
            tick();
            check("rst_no_ack", obs, IDLE_V);
        end
        hilo_ready = 1'b0;

        // Ready arrives on the same edge the counter sits at 255
        wb_req = 1'b1; wb_src = 4'd3; wb_rd = 5'd10; mem_ready = 1'b0;
        tick();
        wb_req = 1'b0;
        for (int i = 0; i < 255; i++) tick();
        check("race_wait", obs, WAIT_V);
        mem_ready = 1'b1;
        tick();
        check("race_write", obs, pk(4'd3, 1'b1, 5'd10, 1'b1, 1'b1, 1'b0, 1'b0));
        mem_ready = 1'b0;
        tick();
        check("race_idle", obs, IDLE_V);

        // Requests while busy are dropped
        wb_req = 1'b1; wb_src = 4'd1; wb_rd = 5'd6; hilo_ready = 1'b0;
        tick();
        check("busy_wait", obs, WAIT_V);
        wb_src = 4'd5; wb_rd = 5'd9;
        for (int i = 0; i < 3; i++) begin
            tick();
            check("busy_req_ignored", obs, WAIT_V);
        end
        wb_req = 1'b0; hilo_ready = 1'b1;
        tick();
        check("busy_write", obs, pk(4'd1, 1'b1, 5'd6, 1'b1, 1'b1, 1'b0, 1'b0));
        hilo_ready = 1'b0;
        tick();
        check("busy_no_ack1", obs, IDLE_V);
        tick();
        check("busy_no_ack2", obs, IDLE_V);

        // Back-to-back: request held across the ack is taken in the following IDLE cycle
        wb_req = 1'b1; wb_src = 4'd4; wb_rd = 5'd2;
        tick();
        check("b2b_first", obs, pk(4'd4, 1'b1, 5'd2, 1'b1, 1'b1, 1'b0, 1'b0));
        wb_src = 4'd7; wb_rd = 5'd3;
        tick();
        check("b2b_gap", obs, IDLE_V);
        tick();
        check("b2b_second", obs, pk(4'd7, 1'b1, 5'd3, 1'b1, 1'b1, 1'b0, 1'b0));
        wb_req = 1'b0;
        tick();
        check("b2b_idle", obs, IDLE_V);

        $display("test done: total=%0d bad=%0d", n_total, n_bad);
        $finish;
    end

endmodule
